tx_word_serializer: RTL and testbench

- Downstream consumer of the 128-bit result stage (Dout/Dout_valid) in the UART demo path.
- Captures one 128-bit result word and streams it as bytes to the UART transmitter through a start/busy handshake.
- Optional mode renders the word as ASCII hex text with a CR/LF terminator, so a PC terminal shows readable results.

---
 rtl/tx_word_serializer_pkg.sv | 24 ++
 rtl/tx_word_serializer_nibble_to_ascii.sv | 21 ++
 rtl/tx_word_serializer.sv | 125 ++++++++++++
 tb/tb_tx_word_serializer.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tx_word_serializer_pkg.sv
// Shared definitions for the 128-bit result word serializer: FSM encoding,
// ASCII constants and the per-frame character count.
package tx_word_serializer_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SEND  = 3'd1,
    ACK   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [7:0] ASCII_CR         = 8'h0D;
  localparam logic [7:0] ASCII_LF         = 8'h0A;
  localparam logic [7:0] ASCII_DIGIT_BASE = 8'h30;
  localparam logic [7:0] ASCII_UPPER_BASE = 8'h41;
  localparam logic [7:0] ASCII_LOWER_BASE = 8'h61;

  // Characters in one frame: payload (hex text or raw bytes) plus optional CR/LF.
  function automatic logic [5:0] frame_chars(input bit hex_ascii, input bit append_crlf);
    return (hex_ascii ? 6'd32 : 6'd16) + (append_crlf ? 6'd2 : 6'd0);
  endfunction

endpackage

// File: rtl/tx_word_serializer_nibble_to_ascii.sv
// Combinational nibble to ASCII hex digit encoder.
module nibble_to_ascii
  import tx_word_serializer_pkg::*;
#(
  parameter int UPPER_CASE = 1
) (
  input  logic [3:0] nibble,
  output logic [7:0] ascii
);

  localparam logic [7:0] ALPHA_BASE = (UPPER_CASE != 0) ? ASCII_UPPER_BASE : ASCII_LOWER_BASE;

  always_comb begin
    if (nibble < 4'd10) begin
      ascii = ASCII_DIGIT_BASE + {4'h0, nibble};
    end else begin
      ascii = ALPHA_BASE + {4'h0, nibble} - 8'd10;
    end
  end

endmodule

// File: rtl/tx_word_serializer.sv
// Captures one 128-bit result word and streams it MSB first to a UART
// transmitter over a start/busy handshake, as raw bytes or ASCII hex text.
module tx_word_serializer
  import tx_word_serializer_pkg::*;
#(
  parameter int HEX_ASCII   = 1,
  parameter int APPEND_CRLF = 1,
  parameter int UPPER_CASE  = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] din,
  input  logic         din_valid,
  output logic         din_ready,
  output logic [7:0]   tx_data,
  output logic         tx_start,
  input  logic         tx_busy,
  output logic         frame_done,
  output logic         overflow
);

  // Handshakes: din is taken on a cycle with din_valid && din_ready (no
  // backpressure on the producer; a strobe while not ready is lost and flagged).
  // On the transmit side tx_start is a one-cycle request issued only while
  // tx_busy is low; the character is done once tx_busy has risen and fallen.

  localparam logic [5:0] PAYLOAD = (HEX_ASCII != 0) ? 6'd32 : 6'd16;
  localparam logic [5:0] N_CHARS = frame_chars(HEX_ASCII != 0, APPEND_CRLF != 0);

  state_t       state;
  state_t       state_next;
  logic [127:0] shreg;
  logic [5:0]   cnt;
  logic [5:0]   cnt_inc;
  logic [7:0]   tx_data_q;
  logic [7:0]   cur_char;
  logic [7:0]   hex_char;
  logic         overflow_q;

  nibble_to_ascii #(
    .UPPER_CASE(UPPER_CASE)
  ) u_nibble_to_ascii (
    .nibble(shreg[127:124]),
    .ascii (hex_char)
  );

  assign cnt_inc = cnt + 6'd1;

  always_comb begin
    cur_char = 8'h00;
    if (cnt < PAYLOAD) begin
      cur_char = (HEX_ASCII != 0) ? hex_char : shreg[127:120];
    end else if (cnt == PAYLOAD) begin
      cur_char = ASCII_CR;
    end else begin
      cur_char = ASCII_LF;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    tx_start   = 1'b0;
    frame_done = 1'b0;
    case (state)
      IDLE: begin
        if (din_valid) state_next = SEND;
      end
      SEND: begin
        if (!tx_busy) begin
          tx_start   = 1'b1;
          state_next = ACK;
        end
      end
      ACK: begin
        if (tx_busy) state_next = DRAIN;
      end
      DRAIN: begin
        if (!tx_busy) state_next = (cnt_inc == N_CHARS) ? DONE : SEND;
      end
      DONE: begin
        frame_done = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign din_ready = (state == IDLE);
  // In SEND the live character is shown; elsewhere the last one sent is held.
  assign tx_data   = (state == SEND) ? cur_char : tx_data_q;
  assign overflow  = overflow_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg      <= '0;
      cnt        <= '0;
      tx_data_q  <= 8'h00;
      overflow_q <= 1'b0;
    end else begin
      if (state == IDLE && din_valid) begin
        shreg <= din;
        cnt   <= '0;
      end
      if (state == SEND) begin
        tx_data_q <= cur_char;
      end
      if (state == DRAIN && !tx_busy) begin
        cnt   <= cnt_inc;
        shreg <= (HEX_ASCII != 0) ? {shreg[123:0], 4'h0} : {shreg[119:0], 8'h00};
      end
      if (din_valid && !din_ready) begin
        overflow_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_tx_word_serializer.sv
// Scoreboard bench for tx_word_serializer: three instances cover hex/upper,
// raw bytes without terminator, and hex/lower-case.
module tb_tx_word_serializer;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] din [3];
  logic [2:0]   din_valid;
  logic [2:0]   force_busy;
  logic [2:0]   busy_model;
  wire  [2:0]   tx_busy;
  wire  [2:0]   din_ready;
  wire  [2:0]   tx_start;
  wire  [2:0]   frame_done;
  wire  [2:0]   overflow;
  wire  [7:0]   tx_data [3];

  int n_vec = 0;
  int n_err = 0;
  int starts [3] = '{0, 0, 0};
  int fd_cnt [3] = '{0, 0, 0};
  int bcnt   [3] = '{0, 0, 0};

  logic [7:0] exp_q0[$];
  logic [7:0] exp_q1[$];
  logic [7:0] exp_q2[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  assign tx_busy = busy_model | force_busy;

  tx_word_serializer dut0 (
    .clk(clk), .rst(rst), .din(din[0]), .din_valid(din_valid[0]), .din_ready(din_ready[0]),
    .tx_data(tx_data[0]), .tx_start(tx_start[0]), .tx_busy(tx_busy[0]),
    .frame_done(frame_done[0]), .overflow(overflow[0])
  );

  tx_word_serializer #(.HEX_ASCII(0), .APPEND_CRLF(0), .UPPER_CASE(1)) dut1 (
    .clk(clk), .rst(rst), .din(din[1]), .din_valid(din_valid[1]), .din_ready(din_ready[1]),
    .tx_data(tx_data[1]), .tx_start(tx_start[1]), .tx_busy(tx_busy[1]),
    .frame_done(frame_done[1]), .overflow(overflow[1])
  );

  tx_word_serializer #(.HEX_ASCII(1), .APPEND_CRLF(1), .UPPER_CASE(0)) dut2 (
    .clk(clk), .rst(rst), .din(din[2]), .din_valid(din_valid[2]), .din_ready(din_ready[2]),
    .tx_data(tx_data[2]), .tx_start(tx_start[2]), .tx_busy(tx_busy[2]),
    .frame_done(frame_done[2]), .overflow(overflow[2])
  );

  // UART transmitter model: busy rises one cycle after tx_start, holds 10 cycles.
  always @(posedge clk) begin
    for (int l = 0; l < 3; l++) begin
      if (tx_start[l]) bcnt[l] <= 10;
      else if (bcnt[l] != 0) bcnt[l] <= bcnt[l] - 1;
    end
  end

  always_comb begin
    busy_model = '0;
    for (int l = 0; l < 3; l++) busy_model[l] = (bcnt[l] != 0);
  end

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input int l, input logic [7:0] v);
    case (l)
      0: exp_q0.push_back(v);
      1: exp_q1.push_back(v);
      default: exp_q2.push_back(v);
    endcase
  endtask

  function automatic int qsize(input int l);
    case (l)
      0: return exp_q0.size();
      1: return exp_q1.size();
      default: return exp_q2.size();
    endcase
  endfunction

  function automatic logic [7:0] pop_exp(input int l);
    case (l)
      0: return exp_q0.pop_front();
      1: return exp_q1.pop_front();
      default: return exp_q2.pop_front();
    endcase
  endfunction

  task automatic push_str(input int l, input string s);
    for (int i = 0; i < s.len(); i++) push_exp(l, s[i]);
  endtask

  task automatic push_crlf(input int l);
    push_exp(l, 8'h0D);
    push_exp(l, 8'h0A);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    for (int l = 0; l < 3; l++) begin
      if (tx_start[l]) begin
        starts[l]++;
        check($sformatf("start_while_busy lane%0d", l), {127'b0, tx_busy[l]}, 128'd0);
        if (qsize(l) == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_tx_start lane%0d: got tx_data %02h, expected no start", l, tx_data[l]);
        end else begin
          check($sformatf("tx_data lane%0d char%0d", l, starts[l]), {120'b0, tx_data[l]}, {120'b0, pop_exp(l)});
        end
      end
      if (frame_done[l]) fd_cnt[l]++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_word(input int l, input logic [127:0] w);
    @(negedge clk);
    din[l]       = w;
    din_valid[l] = 1'b1;
    @(posedge clk);
    #1 din_valid[l] = 1'b0;
  endtask

  task automatic wait_starts(input int l, input int n);
    bit seen = 0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(posedge clk);
      if (starts[l] >= n) seen = 1;
    end
    if (!seen) check($sformatf("wait_starts timeout lane%0d", l), 128'(starts[l]), 128'(n));
  endtask

  task automatic wait_frame(input int l);
    bit seen = 0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge clk);
      if (frame_done[l]) seen = 1;
    end
    if (!seen) begin
      check($sformatf("frame_done timeout lane%0d", l), 128'd0, 128'd1);
    end else begin
      @(negedge clk);
      check($sformatf("frame_done single pulse lane%0d", l), {127'b0, frame_done[l]}, 128'd0);
      check($sformatf("din_ready after frame lane%0d", l), {127'b0, din_ready[l]}, 128'd1);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int base;
    rst        = 1'b1;
    din_valid  = '0;
    force_busy = '0;
    for (int l = 0; l < 3; l++) din[l] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset din_ready", {127'b0, din_ready[0]}, 128'd1);
    check("reset tx_start", {127'b0, tx_start[0]}, 128'd0);
    check("reset tx_data", {120'b0, tx_data[0]}, 128'd0);
    check("reset frame_done", {127'b0, frame_done[0]}, 128'd0);
    check("reset overflow", {127'b0, overflow[0]}, 128'd0);
    rst = 1'b0;

    // Hex frame of the value 8
    for (int i = 0; i < 31; i++) push_exp(0, 8'h30);
    push_exp(0, 8'h38);
    push_crlf(0);
    send_word(0, 128'h8);
    @(negedge clk);
    check("latency tx_start T+1", {127'b0, tx_start[0]}, 128'd1);
    wait_frame(0);
    check("frame_done count", 128'(fd_cnt[0]), 128'd1);
    check("queue drained A", 128'(qsize(0)), 128'd0);

    // Raw bytes, no terminator
    for (int i = 15; i >= 0; i--) push_exp(1, 8'(i));
    send_word(1, 128'h0F0E0D0C0B0A09080706050403020100);
    wait_frame(1);
    check("queue drained raw", 128'(qsize(1)), 128'd0);

    // Upper and lower case letters
    push_exp(0, 8'h41);
    for (int i = 0; i < 30; i++) push_exp(0, 8'h30);
    push_exp(0, 8'h46);
    push_crlf(0);
    send_word(0, {4'hA, 120'h0, 4'hF});
    wait_frame(0);
    push_exp(2, 8'h61);
    for (int i = 0; i < 30; i++) push_exp(2, 8'h30);
    push_exp(2, 8'h66);
    push_crlf(2);
    send_word(2, {4'hA, 120'h0, 4'hF});
    wait_frame(2);
    check("queue drained lower", 128'(qsize(2)), 128'd0);

    // Overflow during character 5; frame must complete unchanged
    push_str(0, "FEDCBA98765432100011223344556677");
    push_crlf(0);
    base = starts[0];
    send_word(0, 128'hFEDCBA98765432100011223344556677);
    wait_starts(0, base + 5);
    send_word(0, {128{1'b1}});
    @(negedge clk);
    check("overflow set", {127'b0, overflow[0]}, 128'd1);
    wait_frame(0);
    repeat (2) @(negedge clk);
    push_str(0, "DEADBEEFCAFEF00D0000000000000001");
    push_crlf(0);
    send_word(0, 128'hDEADBEEF_CAFEF00D_00000000_00000001);
    wait_frame(0);
    check("overflow sticky", {127'b0, overflow[0]}, 128'd1);
    check("queue drained overflow", 128'(qsize(0)), 128'd0);

    // Reset during DRAIN of character 10
    push_str(0, "0123456789");
    base = starts[0];
    send_word(0, 128'h0123456789ABCDEF0123456789ABCDEF);
    wait_starts(0, base + 10);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midframe rst din_ready", {127'b0, din_ready[0]}, 128'd1);
    check("midframe rst tx_start", {127'b0, tx_start[0]}, 128'd0);
    check("midframe rst tx_data", {120'b0, tx_data[0]}, 128'd0);
    check("midframe rst frame_done", {127'b0, frame_done[0]}, 128'd0);
    check("midframe rst overflow", {127'b0, overflow[0]}, 128'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (60) @(negedge clk);
    check("no start after rst", 128'(starts[0]), 128'(base + 10));
    check("queue drained rst", 128'(qsize(0)), 128'd0);

    // Transmitter already busy when the word arrives
    force_busy[0] = 1'b1;
    push_str(0, "13579BDF02468ACE13579BDF02468ACE");
    push_crlf(0);
    base = starts[0];
    send_word(0, 128'h13579BDF02468ACE13579BDF02468ACE);
    repeat (20) @(negedge clk);
    check("held while busy", 128'(starts[0]), 128'(base));
    @(posedge clk);
    #1 force_busy[0] = 1'b0;
    @(negedge clk);
    check("start after busy falls", {127'b0, tx_start[0]}, 128'd1);
    wait_frame(0);
    check("queue drained busy", 128'(qsize(0)), 128'd0);

    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
